// File: rtl/dp_ram_pkg.sv
// Shared constants for the two-port RAM access controller.
// Priority encodings name which requester wins a same-address hazard.
package dp_ram_pkg;
    localparam int ADDR_W_DEF = 2;
    localparam int DATA_W_DEF = 4;
    localparam int CNT_W_DEF  = 8;

    localparam logic PRI_A = 1'b0;
    localparam logic PRI_B = 1'b1;
endpackage

// File: rtl/dp_ram_core.sv
// Two-port memory array with registered read outputs and async clear.
// Callers guarantee that the two ports never collide in a single cycle.
module dp_ram_core
    import dp_ram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_a,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic              we_b,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Reads sample pre-edge contents; read data holds between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            if (re_a) rdata_a <= mem[addr_a];
            if (re_b) rdata_b <= mem[addr_b];
            if (we_a) mem[addr_a] <= wdata_a;
            if (we_b) mem[addr_b] <= wdata_b;
        end
    end
endmodule

// File: rtl/dp_ram_arbiter.sv
// Two-requester access controller: same-address hazard detection, round-robin
// serialisation of conflicts, read-valid tracking and a saturating conflict count.
module dp_ram_arbiter
    import dp_ram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_A,
    input  logic              we_A,
    input  logic [ADDR_W-1:0] addr_A,
    input  logic [DATA_W-1:0] wdata_A,
    output logic              gnt_A,
    output logic              rvalid_A,
    output logic [DATA_W-1:0] rdata_A,
    input  logic              req_B,
    input  logic              we_B,
    input  logic [ADDR_W-1:0] addr_B,
    input  logic [DATA_W-1:0] wdata_B,
    output logic              gnt_B,
    output logic              rvalid_B,
    output logic [DATA_W-1:0] rdata_B,
    output logic              collision,
    output logic [CNT_W-1:0]  coll_cnt,
    output logic              pri_B
);
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic conflict_p0;
    logic wr_A_p0, rd_A_p0, wr_B_p0, rd_B_p0;

    // Stage p0: hazard compare and grants, decided in the request cycle.
    assign conflict_p0 = req_A & req_B & (addr_A == addr_B) & (we_A | we_B);

    // Grants are forced low while reset is held so no access is offered.
    assign gnt_A = ~rst & req_A & (~conflict_p0 | (pri_B == PRI_A));
    assign gnt_B = ~rst & req_B & (~conflict_p0 | (pri_B == PRI_B));

    assign wr_A_p0 = gnt_A & we_A;
    assign rd_A_p0 = gnt_A & ~we_A;
    assign wr_B_p0 = gnt_B & we_B;
    assign rd_B_p0 = gnt_B & ~we_B;

    dp_ram_core #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .we_a    (wr_A_p0),
        .re_a    (rd_A_p0),
        .addr_a  (addr_A),
        .wdata_a (wdata_A),
        .we_b    (wr_B_p0),
        .re_b    (rd_B_p0),
        .addr_b  (addr_B),
        .wdata_b (wdata_B),
        .rdata_a (rdata_A),
        .rdata_b (rdata_B)
    );

    // Stage p1: read-valid strobes, collision pulse, counter and priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_A  <= 1'b0;
            rvalid_B  <= 1'b0;
            collision <= 1'b0;
            coll_cnt  <= '0;
            pri_B     <= PRI_A;
        end else begin
            rvalid_A  <= rd_A_p0;
            rvalid_B  <= rd_B_p0;
            collision <= conflict_p0;
            if (conflict_p0) begin
                coll_cnt <= sat_inc(coll_cnt);
                pri_B    <= ~pri_B;
            end
        end
    end
endmodule

// File: tb/tb_dp_ram_arbiter.sv
// Directed and randomized checks of dp_ram_arbiter against a behavioural model.
module tb_dp_ram_arbiter;
    localparam int AW = 2;
    localparam int DW = 4;
    localparam int CW = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_A, we_A, req_B, we_B;
    logic [AW-1:0] addr_A, addr_B;
    logic [DW-1:0] wdata_A, wdata_B;
    logic          gnt_A, rvalid_A, gnt_B, rvalid_B, collision, pri_B;
    logic [DW-1:0] rdata_A, rdata_B;
    logic [CW-1:0] coll_cnt;

    always #5 clk = ~clk;

    dp_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req_A(req_A), .we_A(we_A), .addr_A(addr_A), .wdata_A(wdata_A),
        .gnt_A(gnt_A), .rvalid_A(rvalid_A), .rdata_A(rdata_A),
        .req_B(req_B), .we_B(we_B), .addr_B(addr_B), .wdata_B(wdata_B),
        .gnt_B(gnt_B), .rvalid_B(rvalid_B), .rdata_B(rdata_B),
        .collision(collision), .coll_cnt(coll_cnt), .pri_B(pri_B)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] mem_m [1 << AW];
    logic          pri_m;
    int            cnt_m;
    logic          rva_m, rvb_m, col_m;
    logic [DW-1:0] rda_m, rdb_m;
    logic          g1, g2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < (1 << AW); i++) mem_m[i] = '0;
        pri_m = 1'b0; cnt_m = 0; col_m = 1'b0;
        rva_m = 1'b0; rvb_m = 1'b0; rda_m = '0; rdb_m = '0;
    endtask

    task automatic check_outputs();
        chk("rvalid_A", 32'(rvalid_A), 32'(rva_m));
        chk("rdata_A", 32'(rdata_A), 32'(rda_m));
        chk("rvalid_B", 32'(rvalid_B), 32'(rvb_m));
        chk("rdata_B", 32'(rdata_B), 32'(rdb_m));
        chk("collision", 32'(collision), 32'(col_m));
        chk("coll_cnt", 32'(coll_cnt), 32'(cnt_m));
        chk("pri_B", 32'(pri_B), 32'(pri_m));
    endtask

    // One clock cycle: drive, check grants, take the edge, check registered outputs.
    task automatic step(input logic ra, input logic wa, input logic [AW-1:0] aa,
                        input logic [DW-1:0] da, input logic rb, input logic wb,
                        input logic [AW-1:0] ab, input logic [DW-1:0] db,
                        output logic ga, output logic gb);
        logic conflict;
        req_A = ra; we_A = wa; addr_A = aa; wdata_A = da;
        req_B = rb; we_B = wb; addr_B = ab; wdata_B = db;
        #1;
        conflict = ra && rb && (aa == ab) && (wa || wb);
        ga = ra && (!conflict || !pri_m);
        gb = rb && (!conflict || pri_m);
        chk("gnt_A", 32'(gnt_A), 32'(ga));
        chk("gnt_B", 32'(gnt_B), 32'(gb));
        @(posedge clk);
        #1;
        rva_m = ga && !wa;
        rvb_m = gb && !wb;
        if (rva_m) rda_m = mem_m[aa];
        if (rvb_m) rdb_m = mem_m[ab];
        if (ga && wa) mem_m[aa] = da;
        if (gb && wb) mem_m[ab] = db;
        col_m = conflict;
        if (conflict) begin
            pri_m = !pri_m;
            if (cnt_m < CNT_MAX) cnt_m++;
        end
        check_outputs();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, g1, g2);
    endtask

    initial begin
        logic          ra, wa, rb, wb, ga, gb, hold_a, hold_b;
        logic [AW-1:0] aa, ab;
        logic [DW-1:0] da, db;

        req_A = 0; we_A = 0; addr_A = '0; wdata_A = '0;
        req_B = 0; we_B = 0; addr_B = '0; wdata_B = '0;
        rst = 1'b1;
        model_reset();
        #12;
        chk("reset gnt_A", 32'(gnt_A), 0);
        chk("reset coll_cnt", 32'(coll_cnt), 0);
        chk("reset pri_B", 32'(pri_B), 0);
        chk("reset rvalid_A", 32'(rvalid_A), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // A writes 0,3,6,9 then reads them back
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, AW'(i), DW'(i * 3), 1'b0, 1'b0, '0, '0, g1, g2);
            chk("wr gnt_A model", 32'(g1), 1);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, AW'(i), '0, 1'b0, 1'b0, '0, '0, g1, g2);
            chk("rd rdata_A const", 32'(rdata_A), 32'(i * 3));
        end
        chk("no coll yet", 32'(coll_cnt), 0);

        // Disjoint writes from both ports
        step(1'b1, 1'b1, 2'd2, 4'd8, 1'b1, 1'b1, 2'd3, 4'd12, g1, g2);
        step(1'b1, 1'b0, 2'd2, '0, 1'b1, 1'b0, 2'd3, '0, g1, g2);
        chk("disjoint rdata_A", 32'(rdata_A), 8);
        chk("disjoint rdata_B", 32'(rdata_B), 12);

        // Write-write conflict on addr0, A holds priority
        step(1'b1, 1'b1, 2'd0, 4'd4, 1'b1, 1'b1, 2'd0, 4'd11, g1, g2);
        chk("ww collision", 32'(collision), 1);
        step(1'b0, 1'b0, 2'd0, '0, 1'b1, 1'b1, 2'd0, 4'd11, g1, g2);
        step(1'b1, 1'b0, 2'd0, '0, 1'b0, 1'b0, '0, '0, g1, g2);
        chk("ww final", 32'(rdata_A), 11);
        chk("ww count", 32'(coll_cnt), 1);

        // Write-read conflict on addr1, B holds priority
        step(1'b1, 1'b1, 2'd1, 4'd7, 1'b1, 1'b0, 2'd1, '0, g1, g2);
        chk("wr old data", 32'(rdata_B), 3);
        step(1'b1, 1'b1, 2'd1, 4'd7, 1'b0, 1'b0, '0, '0, g1, g2);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 2'd1, '0, g1, g2);
        chk("wr new data", 32'(rdata_B), 7);
        chk("wr count", 32'(coll_cnt), 2);

        // Shared read of addr2
        step(1'b1, 1'b0, 2'd2, '0, 1'b1, 1'b0, 2'd2, '0, g1, g2);
        chk("shared rd A", 32'(rdata_A), 8);
        chk("shared rd B", 32'(rdata_B), 8);
        chk("shared no coll", 32'(collision), 0);

        // Randomized traffic with hold-until-grant requesters
        hold_a = 0; hold_b = 0;
        ra = 0; wa = 0; aa = '0; da = '0; rb = 0; wb = 0; ab = '0; db = '0;
        for (int n = 0; n < 200; n++) begin
            if (!hold_a) begin
                ra = ($urandom_range(0, 3) != 0); wa = 1'($urandom_range(0, 1));
                aa = AW'($urandom_range(0, 3)); da = DW'($urandom);
            end
            if (!hold_b) begin
                rb = ($urandom_range(0, 3) != 0); wb = 1'($urandom_range(0, 1));
                ab = AW'($urandom_range(0, 3)); db = DW'($urandom);
            end
            step(ra, wa, aa, da, rb, wb, ab, db, ga, gb);
            hold_a = ra && !ga;
            hold_b = rb && !gb;
        end
        idle();

        // Saturating burst of write-write conflicts
        for (int n = 0; n < 300; n++) begin
            step(1'b1, 1'b1, 2'd0, 4'd1, 1'b1, 1'b1, 2'd0, 4'd2, g1, g2);
        end
        chk("sat count", 32'(coll_cnt), 255);
        for (int n = 0; n < 5; n++) begin
            step(1'b1, 1'b1, 2'd0, 4'd1, 1'b1, 1'b1, 2'd0, 4'd2, g1, g2);
        end

        // Reset asserted mid-burst with requests still driven
        rst = 1'b1;
        #1;
        chk("mid rst gnt_A", 32'(gnt_A), 0);
        chk("mid rst gnt_B", 32'(gnt_B), 0);
        chk("mid rst collision", 32'(collision), 0);
        chk("mid rst coll_cnt", 32'(coll_cnt), 0);
        chk("mid rst pri_B", 32'(pri_B), 0);
        chk("mid rst rvalid_A", 32'(rvalid_A), 0);
        chk("mid rst rdata_B", 32'(rdata_B), 0);
        req_A = 0; req_B = 0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, AW'(i), '0, 1'b1, 1'b0, AW'(3 - i), '0, g1, g2);
            chk("post rst rdata_A", 32'(rdata_A), 0);
        end
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dp_ram_arbiter.md
Name: dp_ram_arbiter

Overview:
Access controller for the team's 2-port RAM. Two independent requesters (A, B) issue reads and writes through a req/gnt handshake. The block detects same-address hazards (write-write, write-read) and serialises conflicting accesses with a round-robin priority bit. It drives an internal memory core, returns registered read data with a valid strobe, and counts resolved collisions.

Parameters:
ADDR_W, 2, address width; depth = 2**ADDR_W
DATA_W, 4, data word width
CNT_W, 8, width of saturating collision counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
req_A  in  1  port A request; held with cmd until gnt_A
we_A  in  1  port A 1=write, 0=read
addr_A  in  ADDR_W  port A address
wdata_A  in  DATA_W  port A write data
gnt_A  out  1  port A accepted this cycle (combinational)
rvalid_A  out  1  port A read data valid (registered)
rdata_A  out  DATA_W  port A read data
req_B, we_B, addr_B, wdata_B, gnt_B, rvalid_B, rdata_B  same as A, for port B
collision  out  1  registered pulse: a conflict was arbitrated last cycle
coll_cnt  out  CNT_W  saturating count of arbitrated conflicts
pri_B  out  1  current priority holder (0=A, 1=B)

Behaviour:
- Reset (async, immediate): all memory words=0, gnt/rvalid/rdata/collision=0, coll_cnt=0, pri_B=0 (A has priority).
- Conflict = req_A & req_B & (addr_A==addr_B) & (we_A | we_B).
- No conflict: gnt_X = req_X for both ports. Simultaneous reads of the same address are both granted.
- Conflict: only the priority holder is granted. The loser's gnt=0 and it must hold its command. On that edge pri_B toggles, so the loser wins any repeat conflict next cycle. Worst-case wait is 1 cycle.
- pri_B changes only on a conflict edge.
- Access commits on the rising edge where req_X & gnt_X.
  - Write: mem[addr] <= wdata.
  - Read: rdata_X <= mem[addr] (pre-edge contents). rvalid_X=1 for exactly the following cycle.
- Read latency is 1 cycle. rdata_X holds its last value when rvalid_X=0.
- Write then read of the same address in consecutive cycles returns the new data.
- A same-cycle write-write or write-read hazard can never reach the core; arbitration guarantees it.
- collision registered: 1 in the cycle after a conflict edge, else 0.
- coll_cnt increments on each conflict edge and saturates at 2**CNT_W-1 (no wrap).
- Reset asserted mid-operation: pending grants are dropped, rvalid clears, memory clears. Requesters must re-issue.
- gnt is combinational from req/we/addr/pri_B, with no path from gnt back to req inside the block.

Decomposition:
- Package dp_ram_pkg: default ADDR_W/DATA_W/CNT_W constants; localparams PRI_A=1'b0, PRI_B=1'b1.
- Sub-module dp_ram_core: 2**ADDR_W x DATA_W array, two write-enable/address/data ports, two registered read outputs, async clear on rst. It assumes conflict-free inputs.
- The arbiter top holds the hazard compare, grant logic, priority flop, rvalid pipeline and counter.

Test Plan:
- Reset then A writes 0,3,6,9 to addr 0..3 (one per cycle, gnt_A=1 each). A reads addr 0..3 -> rvalid_A one cycle after each grant, rdata_A=0,3,6,9; collision=0, coll_cnt=0.
- Same cycle: A write addr2=8, B write addr3=12 -> gnt_A=gnt_B=1. Subsequent reads return 8 and 12; no collision.
- Same cycle: A write addr0=4, B write addr0=11, pri_B=0 -> cycle1 gnt_A=1, gnt_B=0, pri_B->1, collision=1 next cycle. Cycle2 gnt_B=1. Final read addr0=11; coll_cnt=1.
- A write addr1=7 with B read addr1, pri_B=1 -> B granted first, rdata_B = old value (3). A granted next cycle. B re-read returns 7; coll_cnt increments.
- Both read addr2 same cycle -> both granted, rvalid_A=rvalid_B=1 next cycle, rdata=8 on both, no collision.
- Force 300 back-to-back write-write conflicts (CNT_W=8) -> coll_cnt stops at 255. Grants alternate A,B,A,... Assert rst mid-burst -> all outputs 0 immediately and all reads return 0.
